bus_fanout_pipe: RTL

Parametrised interposer between one host-side local bus and NCH child register blocks sharing that bus. Splits the address into a channel index and a child-local offset, and drives one-hot registered write/read strobes to the selected child. Returns the selected child's read data to the host through a latency-matched select pipeline, so every child output reaches the host and none is left dangling. Reports and counts accesses to unpopulated channels.

---
 rtl/bus_fanout_pipe_if.sv | 35 +++
 rtl/bus_fanout_pipe.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/bus_fanout_pipe_if.sv
// Host/child bus bundle for bus_fanout_pipe: host request and response on
// one side, shared child address/data plus per-channel strobes and
// concatenated child read data on the other.
interface bus_fanout_pipe_if #(
  parameter int AW    = 24,
  parameter int DW    = 32,
  parameter int NCH   = 2,
  parameter int SUBAW = 16
);
  logic [AW-1:0]     addr;
  logic [DW-1:0]     din;
  logic              we;
  logic              re;
  logic [DW-1:0]     dout;
  logic              dout_valid;
  logic              miss;
  logic [15:0]       miss_count;
  logic [SUBAW-1:0]  c_addr;
  logic [DW-1:0]     c_din;
  logic [NCH-1:0]    c_we;
  logic [NCH-1:0]    c_re;
  logic [NCH*DW-1:0] c_dout;

  // Fan-out block side
  modport slave (
    input  addr, din, we, re, c_dout,
    output dout, dout_valid, miss, miss_count, c_addr, c_din, c_we, c_re
  );

  // Host plus child-model side
  modport master (
    output addr, din, we, re, c_dout,
    input  dout, dout_valid, miss, miss_count, c_addr, c_din, c_we, c_re
  );
endinterface

// File: rtl/bus_fanout_pipe.sv
// Local-bus interposer: decodes the upper address bits into a child channel,
// drives registered one-hot strobes to that child and returns its read data
// through a select pipeline matched to the child read latency. Accesses to
// unpopulated channels pulse miss, bump a saturating counter and read back
// MISS_VAL.
module bus_fanout_pipe #(
  parameter int          AW       = 24,
  parameter int          DW       = 32,
  parameter int          NCH      = 2,
  parameter int          SUBAW    = 16,
  parameter int          RD_LAT   = 1,
  parameter logic [31:0] MISS_VAL = 32'hDEADBEEF
) (
  input logic              clk,
  input logic              rst_n,
  bus_fanout_pipe_if.slave bus
);

  localparam int            IW      = AW - SUBAW;
  localparam logic [DW-1:0] MISS_DW = DW'(MISS_VAL);

  // Saturating 16-bit increment for the miss counter.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // One-hot strobe for a channel index; compared at 32 bits so a narrow
  // index field can never alias onto a higher channel.
  function automatic logic [NCH-1:0] onehot(input logic [IW-1:0] idx);
    logic [NCH-1:0] v;
    v = '0;
    for (int k = 0; k < NCH; k++)
      if (32'(idx) == 32'(k)) v[k] = 1'b1;
    return v;
  endfunction

  // Read-data mux over the concatenated child outputs.
  function automatic logic [DW-1:0] sel_child(input logic [NCH*DW-1:0] d,
                                              input logic [IW-1:0]     idx);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < NCH; k++)
      if (32'(idx) == 32'(k)) r = d[k*DW +: DW];
    return r;
  endfunction

  logic [IW-1:0] w_idx;
  logic          w_hit;
  logic          w_any;
  logic          w_rd;

  assign w_idx = bus.addr[AW-1:SUBAW];
  assign w_hit = (32'(w_idx) < 32'(NCH));
  assign w_any = bus.we | bus.re;
  // A simultaneous write takes precedence, so the read is dropped entirely.
  assign w_rd  = bus.re & ~bus.we;

  logic [SUBAW-1:0] r_c_addr_p0;
  logic [DW-1:0]    r_c_din_p0;
  logic [NCH-1:0]   r_c_we_p0;
  logic [NCH-1:0]   r_c_re_p0;
  logic             r_miss_p0;
  logic [15:0]      r_miss_cnt;

  // ---- stage p0: request decode -> child strobes, miss reporting ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_c_addr_p0 <= '0;
      r_c_din_p0  <= '0;
      r_c_we_p0   <= '0;
      r_c_re_p0   <= '0;
      r_miss_p0   <= 1'b0;
      r_miss_cnt  <= '0;
    end else begin
      r_c_we_p0 <= '0;
      r_c_re_p0 <= '0;
      r_miss_p0 <= 1'b0;
      if (w_any) begin
        r_c_addr_p0 <= bus.addr[SUBAW-1:0];
        r_c_din_p0  <= bus.din;
        if (w_hit) begin
          if (bus.we) r_c_we_p0 <= onehot(w_idx);
          else        r_c_re_p0 <= onehot(w_idx);
        end else begin
          r_miss_p0  <= 1'b1;
          r_miss_cnt <= sat_inc(r_miss_cnt);
        end
      end
    end
  end

  logic          r_rd_vld_p  [0:RD_LAT];
  logic          r_rd_miss_p [0:RD_LAT];
  logic [IW-1:0] r_rd_idx_p  [0:RD_LAT];

  // ---- stages p[0..RD_LAT]: read tracking, aligned to child latency ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k <= RD_LAT; k++) begin
        r_rd_vld_p[k]  <= 1'b0;
        r_rd_miss_p[k] <= 1'b0;
        r_rd_idx_p[k]  <= '0;
      end
    end else begin
      r_rd_vld_p[0]  <= w_rd;
      r_rd_miss_p[0] <= ~w_hit;
      r_rd_idx_p[0]  <= w_idx;
      for (int k = 1; k <= RD_LAT; k++) begin
        r_rd_vld_p[k]  <= r_rd_vld_p[k-1];
        r_rd_miss_p[k] <= r_rd_miss_p[k-1];
        r_rd_idx_p[k]  <= r_rd_idx_p[k-1];
      end
    end
  end

  logic [DW-1:0] r_dout_po;
  logic          r_dout_vld_po;

  // ---- output stage: capture selected child data or the miss pattern ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dout_po     <= '0;
      r_dout_vld_po <= 1'b0;
    end else begin
      r_dout_vld_po <= r_rd_vld_p[RD_LAT];
      if (r_rd_vld_p[RD_LAT])
        r_dout_po <= r_rd_miss_p[RD_LAT] ? MISS_DW
                                         : sel_child(bus.c_dout, r_rd_idx_p[RD_LAT]);
    end
  end

  assign bus.c_addr     = r_c_addr_p0;
  assign bus.c_din      = r_c_din_p0;
  assign bus.c_we       = r_c_we_p0;
  assign bus.c_re       = r_c_re_p0;
  assign bus.miss       = r_miss_p0;
  assign bus.miss_count = r_miss_cnt;
  assign bus.dout       = r_dout_po;
  assign bus.dout_valid = r_dout_vld_po;

endmodule
